// File: rtl/box_overlay_pkg.sv
// box_overlay_pkg
//   Shared types and constants for the box_overlay block.
//   - state_t   : pixel-pump FSM states (read from upstream, write downstream)
//   - bounds_t  : inclusive box bounds in pixel coordinates, 12 bits each
//   - DEFAULT_BOX_COLOR : default border colour, {R,G,B}
package box_overlay_pkg;

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    typedef struct packed {
        logic [11:0] x_lo;
        logic [11:0] x_hi;
        logic [11:0] y_lo;
        logic [11:0] y_hi;
    } bounds_t;

    localparam logic [23:0] DEFAULT_BOX_COLOR = 24'hFF0000;

endpackage

// File: rtl/box_overlay_geom.sv
// box_geom
//   Combinational conversion of a box given as center + size into inclusive,
//   frame-clamped bounds. The low edge saturates at 0 and the high edge is
//   clamped to the last pixel of the frame. All arithmetic is 13-bit unsigned
//   so that center + size cannot overflow.
//
//   Parameters: WIDTH, HEIGHT - frame size in pixels / lines.
//   Inputs    : center_x, center_y, width, height (12 bits each).
//   Output    : bounds (x_lo, x_hi, y_lo, y_hi).
//   A zero width or height yields meaningless bounds; the caller gates on it.
module box_geom
    import box_overlay_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic [11:0] center_x,
    input  logic [11:0] center_y,
    input  logic [11:0] width,
    input  logic [11:0] height,
    output bounds_t     bounds
);

    localparam logic [12:0] X_MAX = 13'(WIDTH - 1);
    localparam logic [12:0] Y_MAX = 13'(HEIGHT - 1);

    // Returns {lo, hi} for one axis.
    function automatic logic [23:0] axis_bounds(
        input logic [11:0] c,
        input logic [11:0] s,
        input logic [12:0] max_v
    );
        logic [12:0] half;
        logic [12:0] lo;
        logic [12:0] hi;
        half = {2'b00, s[11:1]};
        lo   = ({1'b0, c} >= half) ? ({1'b0, c} - half) : 13'd0;
        hi   = lo + {1'b0, s} - 13'd1;
        if (hi > max_v) begin
            hi = max_v;
        end
        return {lo[11:0], hi[11:0]};
    endfunction

    logic [23:0] x_pair;
    logic [23:0] y_pair;

    always_comb begin
        x_pair = axis_bounds(center_x, width, X_MAX);
        y_pair = axis_bounds(center_y, height, Y_MAX);
        bounds.x_lo = x_pair[23:12];
        bounds.x_hi = x_pair[11:0];
        bounds.y_lo = y_pair[23:12];
        bounds.y_hi = y_pair[11:0];
    end

endmodule

// File: rtl/box_overlay.sv
// box_overlay
//   Copies pixels from an upstream FIFO to a downstream FIFO, one pixel per
//   two cycles at most, replacing pixels on the border of the tracked box with
//   BOX_COLOR. Box updates are held in pending registers and committed when
//   the last pixel of a frame is written, so each frame uses one box.
//
//   Optional feature macro: BOX_OVERLAY_CROSSHAIR_EN
//     defined   -> pixels on the box center row/column inside the box are
//                  also drawn in BOX_COLOR (center values kept at commit).
//     undefined -> border only.
//
//   Ports:
//     clock_50, reset (async, active-low)
//     in_rd_en / in_dout / in_empty     upstream FIFO read port
//     out_wr_en / out_din / out_full    downstream FIFO write port
//     box_valid, center_x/y, width/height  tracker result strobe + box
//     box_active  applied box has nonzero width and height
//     frame_done  one-cycle pulse after the last pixel of a frame is written
module box_overlay
    import box_overlay_pkg::*;
#(
    parameter int          WIDTH     = 640,
    parameter int          HEIGHT    = 480,
    parameter int          THICK     = 2,
    parameter logic [23:0] BOX_COLOR = DEFAULT_BOX_COLOR
) (
    input  logic        clock_50,
    input  logic        reset,
    output logic        in_rd_en,
    input  logic [23:0] in_dout,
    input  logic        in_empty,
    output logic        out_wr_en,
    output logic [23:0] out_din,
    input  logic        out_full,
    input  logic        box_valid,
    input  logic [11:0] center_x,
    input  logic [11:0] center_y,
    input  logic [11:0] width,
    input  logic [11:0] height,
    output logic        box_active,
    output logic        frame_done
);

    localparam logic [11:0] X_LAST  = 12'(WIDTH - 1);
    localparam logic [11:0] Y_LAST  = 12'(HEIGHT - 1);
    localparam logic [12:0] THICK_W = 13'(THICK);

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [11:0] pend_cx_q, pend_cx_d;
    logic [11:0] pend_cy_q, pend_cy_d;
    logic [11:0] pend_w_q, pend_w_d;
    logic [11:0] pend_h_q, pend_h_d;
    bounds_t     act_q, act_d;
    logic        box_active_q, box_active_d;
    logic        frame_done_q, frame_done_d;

    logic        commit;
    logic [11:0] src_cx, src_cy, src_w, src_h;
    bounds_t     geom_bounds;
    logic        in_box;
    logic        on_edge;
    logic        on_cross;
    logic        border;
    logic [12:0] x_e, y_e;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state_q <= S_READ;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_READ:  if (!in_empty) state_d = S_WRITE;
            S_WRITE: if (!out_full) state_d = S_READ;
            default: state_d = S_READ;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Strobes are qualified by reset so nothing is popped or pushed while
    // reset is held, even though the state register already sits in S_READ.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        out_din   = 24'h0;
        case (state_q)
            S_READ: begin
                in_rd_en = reset & ~in_empty;
            end
            S_WRITE: begin
                out_wr_en = reset & ~out_full;
                out_din   = border ? BOX_COLOR : in_dout;
            end
            default: begin
                in_rd_en = 1'b0;
            end
        endcase
    end

    // ---------------- Box source and geometry ----------------
    // A box_valid landing on the commit cycle goes straight to the active
    // bounds rather than waiting a whole frame in pending.
    assign commit = out_wr_en && (x_q == X_LAST) && (y_q == Y_LAST);
    assign src_cx = box_valid ? center_x : pend_cx_q;
    assign src_cy = box_valid ? center_y : pend_cy_q;
    assign src_w  = box_valid ? width    : pend_w_q;
    assign src_h  = box_valid ? height   : pend_h_q;

    box_geom #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_geom (
        .center_x(src_cx),
        .center_y(src_cy),
        .width   (src_w),
        .height  (src_h),
        .bounds  (geom_bounds)
    );

    // ---------------- Raster counter, pending and commit ----------------
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        pend_cx_d    = pend_cx_q;
        pend_cy_d    = pend_cy_q;
        pend_w_d     = pend_w_q;
        pend_h_d     = pend_h_q;
        act_d        = act_q;
        box_active_d = box_active_q;
        frame_done_d = commit;

        if (out_wr_en) begin
            if (x_q == X_LAST) begin
                x_d = 12'd0;
                y_d = (y_q == Y_LAST) ? 12'd0 : y_q + 12'd1;
            end else begin
                x_d = x_q + 12'd1;
            end
        end

        if (box_valid) begin
            pend_cx_d = center_x;
            pend_cy_d = center_y;
            pend_w_d  = width;
            pend_h_d  = height;
        end

        if (commit) begin
            act_d        = geom_bounds;
            box_active_d = (src_w != 12'd0) && (src_h != 12'd0);
        end
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            x_q          <= 12'd0;
            y_q          <= 12'd0;
            pend_cx_q    <= 12'd0;
            pend_cy_q    <= 12'd0;
            pend_w_q     <= 12'd0;
            pend_h_q     <= 12'd0;
            act_q        <= '0;
            box_active_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            pend_cx_q    <= pend_cx_d;
            pend_cy_q    <= pend_cy_d;
            pend_w_q     <= pend_w_d;
            pend_h_q     <= pend_h_d;
            act_q        <= act_d;
            box_active_q <= box_active_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef BOX_OVERLAY_CROSSHAIR_EN
    logic [11:0] act_cx_q, act_cx_d;
    logic [11:0] act_cy_q, act_cy_d;

    always_comb begin
        act_cx_d = act_cx_q;
        act_cy_d = act_cy_q;
        if (commit) begin
            act_cx_d = src_cx;
            act_cy_d = src_cy;
        end
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            act_cx_q <= 12'd0;
            act_cy_q <= 12'd0;
        end else begin
            act_cx_q <= act_cx_d;
            act_cy_q <= act_cy_d;
        end
    end

    assign on_cross = (x_q == act_cx_q) || (y_q == act_cy_q);
`else
    assign on_cross = 1'b0;
`endif

    // ---------------- Border decision ----------------
    // 13-bit compares so x + THICK cannot wrap near the top of the range.
    assign x_e     = {1'b0, x_q};
    assign y_e     = {1'b0, y_q};
    assign in_box  = box_active_q
                   && (x_e >= {1'b0, act_q.x_lo}) && (x_e <= {1'b0, act_q.x_hi})
                   && (y_e >= {1'b0, act_q.y_lo}) && (y_e <= {1'b0, act_q.y_hi});
    assign on_edge = (x_e < {1'b0, act_q.x_lo} + THICK_W)
                   || (x_e + THICK_W > {1'b0, act_q.x_hi})
                   || (y_e < {1'b0, act_q.y_lo} + THICK_W)
                   || (y_e + THICK_W > {1'b0, act_q.y_hi});
    assign border  = in_box && (on_edge || on_cross);

    assign box_active = box_active_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_box_overlay.sv
module tb_box_overlay;

    localparam int          W   = 8;
    localparam int          H   = 4;
    localparam int          TH  = 1;
    localparam int          NPX = W * H;
    localparam logic [23:0] COL = 24'hFF0000;
    localparam logic [23:0] GRN = 24'h00AA00;

    logic        clock_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        in_rd_en;
    logic [23:0] in_dout  = 24'h0;
    logic        in_empty = 1'b1;
    logic        out_wr_en;
    logic [23:0] out_din;
    logic        out_full = 1'b0;
    logic        box_valid = 1'b0;
    logic [11:0] center_x = 12'd0;
    logic [11:0] center_y = 12'd0;
    logic [11:0] width    = 12'd0;
    logic [11:0] height   = 12'd0;
    logic        box_active;
    logic        frame_done;

    always #10 clock_50 = ~clock_50;

    box_overlay #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .THICK    (TH),
        .BOX_COLOR(COL)
    ) dut (
        .clock_50  (clock_50),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .out_wr_en (out_wr_en),
        .out_din   (out_din),
        .out_full  (out_full),
        .box_valid (box_valid),
        .center_x  (center_x),
        .center_y  (center_y),
        .width     (width),
        .height    (height),
        .box_active(box_active),
        .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a one-pixel holding buffer between the FIFOs, the
    // linear position of the next pixel to write, and the box as the tracker
    // supplied it (pending) and as applied to the current frame (active).
    bit          holding;
    logic [23:0] held;
    int          pos;
    int          frame_no;
    int          wr_cnt;
    int          fd_count;
    int          pend_cx, pend_cy, pend_w, pend_h;
    int          act_cx, act_cy, act_w, act_h;
    bit          exp_fd;
    int          src_mode;      // 0 constant, 1 incrementing, 2 random
    logic [23:0] src_pat;
    logic [23:0] rec [0:15][0:NPX-1];

    bit          obs_rd, obs_wr, obs_fd, obs_act;
    logic [23:0] obs_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (frame %0d pos %0d t=%0t)",
                     name, act, exp, frame_no, pos, $time);
        end
    endtask

    function automatic bit is_border(input int px, input int py);
        int xl, xh, yl, yh;
        if (act_w == 0 || act_h == 0) return 1'b0;
        xl = act_cx - act_w / 2; if (xl < 0) xl = 0;
        xh = xl + act_w - 1;     if (xh > W - 1) xh = W - 1;
        yl = act_cy - act_h / 2; if (yl < 0) yl = 0;
        yh = yl + act_h - 1;     if (yh > H - 1) yh = H - 1;
        if (!(px >= xl && px <= xh && py >= yl && py <= yh)) return 1'b0;
`ifdef BOX_OVERLAY_CROSSHAIR_EN
        if (px == act_cx || py == act_cy) return 1'b1;
`endif
        return (px < xl + TH) || (px + TH > xh) || (py < yl + TH) || (py + TH > yh);
    endfunction

    function automatic logic [23:0] pix(input int f, input int x, input int y);
        return rec[f][y * W + x];
    endfunction

    // One clock: compare at the falling edge, then advance the model by the
    // events that the rising edge performs, then let the caller set inputs.
    task automatic step();
        bit          e_rd, e_wr;
        logic [23:0] e_din;
        @(negedge clock_50);
        e_rd  = reset && !holding && !in_empty;
        e_wr  = reset && holding && !out_full;
        e_din = !holding ? 24'h0 : (is_border(pos % W, pos / W) ? COL : held);
        obs_rd  = in_rd_en;
        obs_wr  = out_wr_en;
        obs_din = out_din;
        obs_fd  = frame_done;
        obs_act = box_active;
        if (obs_fd) fd_count++;
        chk("in_rd_en",   32'(obs_rd),  32'(e_rd));
        chk("out_wr_en",  32'(obs_wr),  32'(e_wr));
        chk("out_din",    32'(obs_din), 32'(e_din));
        chk("box_active", 32'(obs_act), 32'(act_w != 0 && act_h != 0));
        chk("frame_done", 32'(obs_fd),  32'(exp_fd));
        @(posedge clock_50);
        #1;
        exp_fd = 1'b0;
        if (e_wr) begin
            if (frame_no < 16) rec[frame_no][pos] = obs_din;
            wr_cnt++;
            holding = 1'b0;
            if (pos == NPX - 1) begin
                if (box_valid) begin
                    act_cx = int'(center_x); act_cy = int'(center_y);
                    act_w  = int'(width);    act_h  = int'(height);
                end else begin
                    act_cx = pend_cx; act_cy = pend_cy; act_w = pend_w; act_h = pend_h;
                end
                exp_fd = 1'b1;
                pos = 0;
                frame_no++;
            end else begin
                pos++;
            end
        end
        if (box_valid) begin
            pend_cx = int'(center_x); pend_cy = int'(center_y);
            pend_w  = int'(width);    pend_h  = int'(height);
        end
        box_valid = 1'b0;
        if (e_rd) begin
            if (src_mode == 2) held = 24'($urandom);
            else held = src_pat;
            if (src_mode == 1) src_pat = src_pat + 24'd1;
            in_dout = held;
            holding = 1'b1;
        end
    endtask

    task automatic clear_model();
        if (pos != 0) frame_no++;
        holding = 1'b0; pos = 0; exp_fd = 1'b0; box_valid = 1'b0;
        pend_cx = 0; pend_cy = 0; pend_w = 0; pend_h = 0;
        act_cx = 0; act_cy = 0; act_w = 0; act_h = 0;
    endtask

    task automatic set_box(input int cx, input int cy, input int w, input int h);
        box_valid = 1'b1;
        center_x = 12'(cx); center_y = 12'(cy); width = 12'(w); height = 12'(h);
    endtask

    // Run until n more pixels are written; mode 1 randomizes flags and boxes.
    task automatic run_writes(input int n, input int mode);
        int target;
        int budget;
        target = wr_cnt + n;
        budget = n * 10 + 20;
        while (wr_cnt < target && budget > 0) begin
            if (mode == 1) begin
                in_empty = ($urandom_range(0, 3) == 0);
                out_full = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 9) == 0)
                    set_box($urandom_range(0, 11), $urandom_range(0, 7),
                            $urandom_range(0, 10), $urandom_range(0, 6));
            end else begin
                in_empty = 1'b0;
                out_full = 1'b0;
            end
            step();
            budget--;
        end
        chk("run_writes_done", 32'(wr_cnt), 32'(target));
    endtask

    initial begin
        int f0, n, bp_rd, bp_wr, b;
        logic [23:0] held_val;
        holding = 0; pos = 0; frame_no = 0; wr_cnt = 0; fd_count = 0;
        src_mode = 0; src_pat = GRN;
        clear_model();

        // Reset held for three cycles with data available upstream.
        #1;
        reset    = 1'b0;
        in_empty = 1'b0;
        repeat (3) begin
            step();
            chk("rst_in_rd_en",   32'(obs_rd),  32'd0);
            chk("rst_out_wr_en",  32'(obs_wr),  32'd0);
            chk("rst_box_active", 32'(obs_act), 32'd0);
            chk("rst_out_din",    32'(obs_din), 32'd0);
        end
        reset = 1'b1;
        step();
        chk("first_read", 32'(obs_rd), 32'd1);

        // Frame 0: no box, constant green.
        f0 = fd_count;
        run_writes(32, 0);
        in_empty = 1'b1;
        step();
        chk("nobox_frame_done_pulses", 32'(fd_count - f0), 32'd1);
        n = 0;
        for (int i = 0; i < NPX; i++) if (rec[0][i] == GRN) n++;
        chk("nobox_green_count", 32'(n), 32'd32);

        // Frame 1 carries the box update, frame 2 shows it.
        run_writes(5, 0);
        set_box(4, 2, 4, 3);
        run_writes(NPX - pos, 0);
        run_writes(32, 0);
        n = 0;
        for (int i = 0; i < NPX; i++) if (rec[1][i] == GRN) n++;
        chk("box_frame1_unchanged", 32'(n), 32'd32);
        chk("box_2_1", 32'(pix(2, 2, 1)), 32'(COL));
        chk("box_5_1", 32'(pix(2, 5, 1)), 32'(COL));
        chk("box_3_3", 32'(pix(2, 3, 3)), 32'(COL));
        chk("box_2_2", 32'(pix(2, 2, 2)), 32'(COL));
        chk("box_5_2", 32'(pix(2, 5, 2)), 32'(COL));
        chk("box_3_2", 32'(pix(2, 3, 2)), 32'(GRN));
        chk("box_4_2", 32'(pix(2, 4, 2)), 32'(GRN));
        chk("box_1_1", 32'(pix(2, 1, 1)), 32'(GRN));
        chk("box_6_3", 32'(pix(2, 6, 3)), 32'(GRN));
        chk("box_4_0", 32'(pix(2, 4, 0)), 32'(GRN));
        chk("box_active_on", 32'(obs_act), 32'd1);

        // Frame 3: backpressure mid-line with an incrementing pixel sequence.
        src_mode = 1; src_pat = 24'h100000;
        run_writes(3, 0);
        in_empty = 1'b0;
        out_full = 1'b1;
        b = 0;
        while (!holding && b < 10) begin step(); b++; end
        chk("bp_holding", 32'(holding), 32'd1);
        held_val = held;
        bp_rd = 0; bp_wr = 0;
        repeat (10) begin
            step();
            bp_rd += int'(obs_rd);
            bp_wr += int'(obs_wr);
        end
        chk("bp_no_write", 32'(bp_wr), 32'd0);
        chk("bp_no_read",  32'(bp_rd), 32'd0);
        out_full = 1'b0;
        step();
        chk("bp_release_write", 32'(obs_wr),  32'd1);
        chk("bp_release_data",  32'(obs_din), 32'(held_val));
        set_box(0, 0, 4, 4);
        run_writes(NPX - pos, 0);
        chk("bp_seq_3", 32'(pix(3, 3, 0)), 32'(held_val));
        chk("bp_seq_4", 32'(pix(3, 4, 0)), 32'(held_val + 24'd1));
        chk("bp_seq_5", 32'(pix(3, 5, 0)), 32'(held_val + 24'd2));

        // Frame 4: clamped box from center (0,0), size 4x4 -> 0..3 x 0..3.
        src_mode = 0; src_pat = GRN;
        run_writes(32, 0);
        chk("clamp_0_0", 32'(pix(4, 0, 0)), 32'(COL));
        chk("clamp_3_0", 32'(pix(4, 3, 0)), 32'(COL));
        chk("clamp_0_3", 32'(pix(4, 0, 3)), 32'(COL));
        chk("clamp_3_3", 32'(pix(4, 3, 3)), 32'(COL));
        chk("clamp_1_1", 32'(pix(4, 1, 1)), 32'(GRN));
        chk("clamp_2_2", 32'(pix(4, 2, 2)), 32'(GRN));
        chk("clamp_4_0", 32'(pix(4, 4, 0)), 32'(GRN));

        // Frame 5 clears the box; frame 6 ends with a coincident update.
        run_writes(2, 0);
        set_box(3, 3, 0, 2);
        run_writes(NPX - pos, 0);
        in_empty = 1'b1;
        step();
        chk("zero_box_inactive", 32'(obs_act), 32'd0);
        b = 0;
        while (!(pos == NPX - 1 && holding) && b < 200) begin
            in_empty = 1'b0; out_full = 1'b0;
            step(); b++;
        end
        chk("coinc_reached_last", 32'(pos), 32'(NPX - 1));
        out_full = 1'b0;
        set_box(6, 1, 3, 2);
        step();
        chk("coinc_last_write", 32'(obs_wr), 32'd1);
        step();
        chk("coinc_box_active", 32'(obs_act), 32'd1);
        chk("coinc_frame_done", 32'(obs_fd),  32'd1);
        run_writes(NPX - pos, 0);
        chk("coinc_5_0", 32'(pix(7, 5, 0)), 32'(COL));
        chk("coinc_7_1", 32'(pix(7, 7, 1)), 32'(COL));
        chk("coinc_6_1", 32'(pix(7, 6, 1)), 32'(COL));
        chk("coinc_4_0", 32'(pix(7, 4, 0)), 32'(GRN));
        chk("coinc_5_2", 32'(pix(7, 5, 2)), 32'(GRN));

        // Randomized traffic, flags and box updates, with a mid-frame reset.
        src_mode = 2;
        run_writes(150, 1);
        run_writes(5, 1);
        reset = 1'b0;
        clear_model();
        repeat (2) step();
        reset = 1'b1;
        run_writes(200, 1);
        in_empty = 1'b1;
        out_full = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
